// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the register CPU datapath.
// Handles wait states, timeout fault, halt, and retired-instruction count.
module ctrl_sequencer #(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mar_load,
    output logic              ir_load,
    output logic              mdr_load,
    output logic              reg_load,
    output logic              ram_load,
    output logic              incr_pc,
    output logic [1:0]        byte_enable,
    output logic [2:0]        regr0s,
    output logic [2:0]        regr1s,
    output logic [2:0]        regws,
    output logic [1:0]        op0s,
    output logic [1:0]        op1s,
    output logic [1:0]        mdrs,
    output logic [DATA_W-4:0] irimm,
    output logic [2:0]        state,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam int ST_W = $clog2(TIMEOUT + 2);

    state_t            st_q, st_d;
    logic [ST_W-1:0]   stall_q;
    logic [CNT_W-1:0]  ret_q;
    logic [2:0]        opc, arg1, tgt;
    logic              stalled, timeout_hit;

    assign opc  = instr[DATA_W-1 -: 3];
    assign arg1 = instr[5:3];
    assign tgt  = instr[2:0];

    always_comb begin
        irimm = '0;
        if (opc == 3'b000 || opc == 3'b011)
            irimm = {6'b0, instr[DATA_W-4:6]};
        else if (opc == 3'b101)
            irimm = {3'b0, instr[DATA_W-4:3]};
    end

    always_comb begin
        st_d        = st_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mar_load    = 1'b0;
        ir_load     = 1'b0;
        mdr_load    = 1'b0;
        reg_load    = 1'b0;
        ram_load    = 1'b0;
        incr_pc     = 1'b0;
        byte_enable = 2'b11;
        regr0s      = 3'd0;
        regr1s      = 3'd0;
        regws       = 3'd0;
        op0s        = 2'd0;
        op1s        = 2'd0;
        mdrs        = 2'd0;
        stalled     = 1'b0;
        timeout_hit = 1'b0;
        // Reset suppresses every strobe, including one mid-access.
        if (!reset) begin
            case (st_q)
                S_DECODE: begin
                    if (opc == 3'b000 || opc == 3'b011 || opc == 3'b101)
                        mdr_load = 1'b1;
                    unique case (1'b1)
                        (opc == 3'b000), (opc == 3'b011): st_d = S_READ;
                        (opc == 3'b101):                  st_d = S_EXEC;
                        (opc == 3'b111):                  st_d = S_HALT;
                        default:                          st_d = S_FETCH;
                    endcase
                end
                S_READ: begin
                    regr0s   = arg1;
                    op0s     = 2'd2;
                    mar_load = 1'b1;
                    st_d     = S_EXEC;
                end
                S_EXEC: begin
                    unique case (1'b1)
                        (opc == 3'b000): begin
                            mem_req  = 1'b1;
                            mdrs     = 2'd1;
                            mdr_load = mem_ready;
                            if (mem_ready) st_d = S_WB;
                        end
                        (opc == 3'b011): begin
                            regr0s      = tgt;
                            mdrs        = 2'd2;
                            mem_req     = 1'b1;
                            mem_we      = 1'b1;
                            byte_enable = 2'b01;
                            ram_load    = mem_ready;
                            if (mem_ready) st_d = S_FETCH;
                        end
                        (opc == 3'b101): begin
                            op0s     = 2'd2;
                            regws    = tgt;
                            reg_load = 1'b1;
                            st_d     = S_FETCH;
                        end
                        default: st_d = S_FETCH;
                    endcase
                end
                S_WB: begin
                    op0s     = 2'd2;
                    regws    = tgt;
                    reg_load = 1'b1;
                    st_d     = S_FETCH;
                end
                S_HALT:  st_d = S_HALT;
                S_FAULT: st_d = S_FAULT;
                default: begin
                    regr1s  = 3'd7;
                    op1s    = 2'd1;
                    mem_req = 1'b1;
                    ir_load = mem_ready;
                    incr_pc = mem_ready;
                    st_d    = mem_ready ? S_DECODE : S_FETCH;
                end
            endcase
            stalled = mem_req && !mem_ready;
            // Trips on the TIMEOUT-th consecutive stalled cycle.
            timeout_hit = (TIMEOUT != 0) && stalled
                       && (stall_q == ST_W'(TIMEOUT - 1));
            if (timeout_hit) st_d = S_FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= S_FETCH;
            stall_q <= '0;
            ret_q   <= '0;
        end else begin
            st_q    <= st_d;
            stall_q <= (stalled && st_d == st_q) ? stall_q + 1'b1 : '0;
            if (st_d == S_FETCH &&
                (st_q == S_DECODE || st_q == S_EXEC || st_q == S_WB))
                ret_q <= ret_q + 1'b1;
        end
    end

    assign state   = st_q;
    assign halted  = (st_q == S_HALT);
    assign fault   = (st_q == S_FAULT);
    assign retired = ret_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized bench for ctrl_sequencer against a phase-list reference model.
// Uses TIMEOUT=4 so wait states of up to 3 complete and 4 trip the fault.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mar_load, ir_load, mdr_load;
    logic        reg_load, ram_load, incr_pc;
    logic [1:0]  byte_enable, op0s, op1s, mdrs;
    logic [2:0]  regr0s, regr1s, regws, state;
    logic [12:0] irimm;
    logic        halted, fault;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;
    int ret_m  = 0;

    ctrl_sequencer #(.DATA_W(16), .CNT_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mar_load(mar_load),
        .ir_load(ir_load), .mdr_load(mdr_load), .reg_load(reg_load),
        .ram_load(ram_load), .incr_pc(incr_pc), .byte_enable(byte_enable),
        .regr0s(regr0s), .regr1s(regr1s), .regws(regws), .op0s(op0s),
        .op1s(op1s), .mdrs(mdrs), .irimm(irimm), .state(state),
        .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [27:0] obs;
    assign obs = {state, mem_req, mem_we, mar_load, ir_load, mdr_load,
                  reg_load, ram_load, incr_pc, byte_enable, regr0s,
                  regr1s, regws, op0s, op1s, mdrs};

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Expected outputs for a phase (0=F 1=D 2=R 3=E 4=WB 5=H 6=FAULT).
    function automatic logic [27:0] exp_vec(input int p,
                                            input logic [15:0] ins,
                                            input logic rdy);
        logic [2:0] opc;
        logic mr, mw, mar, ir, mdr, rl, ram, pc;
        logic [1:0] be, o0, o1, ms;
        logic [2:0] r0, r1, ws;
        opc = ins[15:13];
        {mr, mw, mar, ir, mdr, rl, ram, pc} = 8'h0;
        be = 2'b11; o0 = 0; o1 = 0; ms = 0; r0 = 0; r1 = 0; ws = 0;
        case (p)
            0: begin r1 = 7; o1 = 1; mr = 1; ir = rdy; pc = rdy; end
            1: if (opc == 0 || opc == 3 || opc == 5) mdr = 1;
            2: begin r0 = ins[5:3]; o0 = 2; mar = 1; end
            3: begin
                if (opc == 0) begin mr = 1; ms = 1; mdr = rdy; end
                else if (opc == 3) begin
                    r0 = ins[2:0]; ms = 2; mr = 1; mw = 1;
                    be = 2'b01; ram = rdy;
                end else if (opc == 5) begin
                    o0 = 2; ws = ins[2:0]; rl = 1;
                end
            end
            4: begin o0 = 2; ws = ins[2:0]; rl = 1; end
            default: ;
        endcase
        return {3'(p), mr, mw, mar, ir, mdr, rl, ram, pc, be,
                r0, r1, ws, o0, o1, ms};
    endfunction

    function automatic logic [12:0] exp_imm(input logic [15:0] ins);
        logic [2:0] opc;
        opc = ins[15:13];
        if (opc == 0 || opc == 3) return {6'b0, ins[12:6]};
        if (opc == 5) return {3'b0, ins[12:3]};
        return 13'h0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        instr = 16'($urandom);
        #2;
        chk("rst_strobes", 32'(obs[24:17]), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        ret_m = 0;
        chk("rst_after", 32'({state, halted, fault, retired}), 32'h0);
    endtask

    // Runs one instruction; wf/wx = wait cycles in FETCH/EXEC access.
    // abort_p >= 0 asserts reset on the first cycle of that phase.
    task automatic run_instr(input logic [15:0] ins, input int wf,
                             input int wx, input int abort_p);
        logic [2:0] opc;
        int ph[$];
        int nw;
        logic mem, rdy;
        opc = ins[15:13];
        case (opc)
            3'd0:    ph = '{0, 1, 2, 3, 4};
            3'd3:    ph = '{0, 1, 2, 3};
            3'd5:    ph = '{0, 1, 3};
            default: ph = '{0, 1};
        endcase
        foreach (ph[i]) begin
            mem = (ph[i] == 0) || (ph[i] == 3 && (opc == 0 || opc == 3));
            nw = !mem ? 0 : (ph[i] == 0 ? wf : wx);
            for (int w = 0; w <= nw; w++) begin
                rdy = (w == nw);
                instr = ins;
                mem_ready = mem ? rdy : 1'($urandom);
                if (ph[i] == abort_p) begin
                    reset = 1'b1;
                    mem_ready = 1'b1;
                    #2;
                    chk("abort_strb",
                        32'({ram_load, mem_req, mem_we}), 32'h0);
                    @(posedge clk); #1;
                    reset = 1'b0;
                    ret_m = 0;
                    chk("abort_after", 32'({state, retired}), 32'h0);
                    return;
                end
                #2;
                chk($sformatf("ph%0d_op%0d", ph[i], opc),
                    32'(obs), 32'(exp_vec(ph[i], ins, rdy)));
                chk("irimm", 32'(irimm), 32'(exp_imm(ins)));
                @(posedge clk); #1;
            end
        end
        if (opc == 3'd7) begin
            chk("halt_enter", 32'({state, halted}), {28'h0, 3'd5, 1'b1});
        end else begin
            ret_m = (ret_m + 1) & 16'hFFFF;
            chk("retired", 32'(retired), 32'(ret_m));
        end
    endtask

    initial begin
        logic [15:0] ins;
        logic [2:0]  opc;

        do_reset();

        // LDI 0xA153: irimm 0x02A, reg_load with regws=3 in cycle 3.
        chk("ldi_imm", 32'(exp_imm(16'hA153)), 32'h02A);
        run_instr(16'hA153, 0, 0, -1);

        // Load word arg1=2 tgt=5, two EXEC wait states.
        run_instr(16'h0A15, 0, 2, -1);

        // Store byte tgt=4, one EXEC wait state.
        run_instr(16'h6C24, 1, 1, -1);

        // NOP opcode 010.
        run_instr(16'h4123, 0, 0, -1);

        // Three stalled cycles then ready: completes at the boundary.
        run_instr(16'h0A15, 3, 3, -1);

        // Four stalled fetch cycles trip the fault.
        do_reset();
        instr = 16'h0000;
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'b0;
            #2;
            chk("to_stall", 32'(obs), 32'(exp_vec(0, instr, 1'b0)));
            @(posedge clk); #1;
        end
        chk("to_fault", 32'({state, fault, halted}), {28'h0, 3'd6, 2'b10});
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'($urandom);
            #2;
            chk("fault_idle", 32'(obs), 32'(exp_vec(6, instr, 1'b0)));
            @(posedge clk); #1;
        end
        do_reset();

        // Halt, then idle for 20 cycles.
        run_instr(16'hE000, 0, 0, -1);
        for (int c = 0; c < 20; c++) begin
            instr = 16'($urandom);
            mem_ready = 1'($urandom);
            #2;
            chk("halt_idle", 32'({obs, halted}),
                32'({exp_vec(5, instr, 1'b0), 1'b1}));
            @(posedge clk); #1;
        end
        do_reset();

        // Reset during an EXEC store with mem_ready high.
        run_instr(16'h4000, 0, 0, -1);
        run_instr(16'h6C24, 0, 0, 3);

        // Randomized mix; stalls bounded below the timeout.
        for (int n = 0; n < 60; n++) begin
            opc = 3'($urandom_range(0, 6));
            ins = {opc, 13'($urandom)};
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
